// File: rtl/branch_pkg.sv
// Shared constants, state encoding and helpers for the multi-cycle branch comparator.
// Optional feature macro used by the top: BRANCH_EARLY_EXIT_EN.
package branch_pkg;

  localparam logic [2:0] BEQ  = 3'b000;
  localparam logic [2:0] BNE  = 3'b001;
  localparam logic [2:0] BLT  = 3'b100;
  localparam logic [2:0] BGE  = 3'b101;
  localparam logic [2:0] BLTU = 3'b110;
  localparam logic [2:0] BGEU = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // Guarded against CHUNK=0 so a bad configuration reaches the elaboration check.
  function automatic int num_chunks(input int xlen, input int chunk);
    return (chunk < 1) ? 1 : xlen / chunk;
  endfunction

  function automatic logic is_unsigned_cmp(input logic [2:0] f3);
    return f3[2] & f3[1];
  endfunction

  function automatic logic is_illegal(input logic [2:0] f3);
    return (f3 == 3'b010) || (f3 == 3'b011);
  endfunction

  function automatic logic branch_taken(input logic [2:0] f3, input logic eq, input logic lt);
    case (f3)
      BEQ:       return eq;
      BNE:       return !eq;
      BLT, BLTU: return lt;
      BGE, BGEU: return !lt;
      default:   return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/branch_comp_seq_if.sv
// Request/response handshake bundle between the register-read stage and the comparator.
interface branch_comp_seq_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [2:0]      funct3;
  logic [XLEN-1:0] data_a;
  logic [XLEN-1:0] data_b;
  logic            out_valid;
  logic            out_ready;
  logic            br_eq;
  logic            br_lt;
  logic            taken;
  logic            illegal;

  modport master (
    output in_valid, funct3, data_a, data_b, out_ready,
    input  in_ready, out_valid, br_eq, br_lt, taken, illegal
  );

  modport slave (
    input  in_valid, funct3, data_a, data_b, out_ready,
    output in_ready, out_valid, br_eq, br_lt, taken, illegal
  );
endinterface

// File: rtl/branch_chunk_cmp.sv
// Combinational unsigned compare of one CHUNK-wide operand slice.
module branch_chunk_cmp #(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] i_a,
  input  logic [CHUNK-1:0] i_b,
  output logic             o_eq,
  output logic             o_lt
);
  assign o_eq = (i_a == i_b);
  assign o_lt = (i_a < i_b);
endmodule

// File: rtl/branch_comp_seq.sv
// Multi-cycle RV32I branch comparator: MSB-first chunked compare behind a valid/ready handshake.
// Define BRANCH_EARLY_EXIT_EN to finish on the first differing chunk instead of a fixed N cycles.
module branch_comp_seq
  import branch_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CHUNK = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  branch_comp_seq_if.slave  bus
);

  localparam int N = num_chunks(XLEN, CHUNK);
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(N - 1);
  localparam logic [XLEN-1:0] SIGN_BIT = XLEN'(1) << (XLEN - 1);

  generate
    if (CHUNK < 1 || (XLEN % CHUNK) != 0) begin : g_bad_cfg
      $error("branch_comp_seq: XLEN must be a non-zero multiple of CHUNK");
    end
  endgenerate

  state_t           r_state;
  logic [XLEN-1:0]  r_a;
  logic [XLEN-1:0]  r_b;
  logic [2:0]       r_f3;
  logic [IDX_W-1:0] r_idx;
  logic             r_diff;
  logic             r_lt;
  logic             r_ill;
  logic             r_out_valid;
  logic             r_br_eq;
  logic             r_br_lt;
  logic             r_taken;
  logic             r_illegal;

  logic [CHUNK-1:0] w_a_chunks [N];
  logic [CHUNK-1:0] w_b_chunks [N];
  logic [CHUNK-1:0] w_a_sel;
  logic [CHUNK-1:0] w_b_sel;
  logic             w_chunk_eq;
  logic             w_chunk_lt;
  logic [XLEN-1:0]  w_flip;
  logic             w_first_diff;
  logic             w_eq_final;
  logic             w_lt_final;
  logic             w_finish;

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_chunk
      assign w_a_chunks[gi] = r_a[gi*CHUNK +: CHUNK];
      assign w_b_chunks[gi] = r_b[gi*CHUNK +: CHUNK];
    end
  endgenerate

  assign w_a_sel = w_a_chunks[r_idx];
  assign w_b_sel = w_b_chunks[r_idx];

  branch_chunk_cmp #(.CHUNK(CHUNK)) u_chunk_cmp (
    .i_a  (w_a_sel),
    .i_b  (w_b_sel),
    .o_eq (w_chunk_eq),
    .o_lt (w_chunk_lt)
  );

  // Flipping the sign bit at capture turns a signed compare into a plain unsigned one.
  assign w_flip       = is_unsigned_cmp(bus.funct3) ? '0 : SIGN_BIT;
  assign w_first_diff = !r_diff && !w_chunk_eq;
  assign w_eq_final   = !r_diff && w_chunk_eq;
  assign w_lt_final   = r_diff ? r_lt : (!w_chunk_eq && w_chunk_lt);

`ifdef BRANCH_EARLY_EXIT_EN
  assign w_finish = (r_idx == '0) || w_first_diff;
`else
  assign w_finish = (r_idx == '0);
`endif

  assign bus.in_ready  = (r_state == IDLE);
  assign bus.out_valid = r_out_valid;
  assign bus.br_eq     = r_br_eq;
  assign bus.br_lt     = r_br_lt;
  assign bus.taken     = r_taken;
  assign bus.illegal   = r_illegal;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_a         <= '0;
      r_b         <= '0;
      r_f3        <= '0;
      r_idx       <= '0;
      r_diff      <= 1'b0;
      r_lt        <= 1'b0;
      r_ill       <= 1'b0;
      r_out_valid <= 1'b0;
      r_br_eq     <= 1'b0;
      r_br_lt     <= 1'b0;
      r_taken     <= 1'b0;
      r_illegal   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.in_valid) begin
            r_a     <= bus.data_a ^ w_flip;
            r_b     <= bus.data_b ^ w_flip;
            r_f3    <= bus.funct3;
            r_idx   <= IDX_TOP;
            r_diff  <= 1'b0;
            r_lt    <= 1'b0;
            r_ill   <= is_illegal(bus.funct3);
            r_state <= BUSY;
          end
        end
        BUSY: begin
          // An illegal op spends exactly one BUSY cycle so its result appears one edge after accept.
          if (r_ill) begin
            r_state     <= DONE;
            r_out_valid <= 1'b1;
            r_illegal   <= 1'b1;
            r_br_eq     <= 1'b0;
            r_br_lt     <= 1'b0;
            r_taken     <= 1'b0;
          end else if (w_finish) begin
            r_state     <= DONE;
            r_out_valid <= 1'b1;
            r_illegal   <= 1'b0;
            r_br_eq     <= w_eq_final;
            r_br_lt     <= w_lt_final;
            r_taken     <= branch_taken(r_f3, w_eq_final, w_lt_final);
          end else begin
            if (w_first_diff) begin
              r_diff <= 1'b1;
              r_lt   <= w_chunk_lt;
            end
            r_idx <= r_idx - IDX_W'(1);
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_branch_comp_seq.sv
// Scoreboard bench for branch_comp_seq: directed cases plus randomized ops against a behavioural model.
module tb_branch_comp_seq;

  localparam int XLEN  = 32;
  localparam int CHUNK = 8;
  localparam int N     = XLEN / CHUNK;

  typedef struct {
    bit ill;
    bit eq;
    bit lt;
    bit tk;
    int acc;
    int lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  int   rdy_mode = 1;   // 0: low, 1: high, 2: random
  bit   seen = 1'b0;
  exp_t q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  branch_comp_seq_if #(.XLEN(XLEN)) bif ();

  branch_comp_seq #(.XLEN(XLEN), .CHUNK(CHUNK)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bif)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic exp_t model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b, input int acc);
    exp_t e;
    logic [31:0] x;
    e.acc = acc;
    e.ill = (f3 == 3'd2) || (f3 == 3'd3);
    e.eq = 0;
    e.lt = 0;
    e.tk = 0;
    e.lat = 1;
    if (!e.ill) begin
      e.eq = (a == b);
      e.lt = (f3 == 3'd6 || f3 == 3'd7) ? (a < b) : ($signed(a) < $signed(b));
      case (f3)
        3'd0: e.tk = e.eq;
        3'd1: e.tk = !e.eq;
        3'd4, 3'd6: e.tk = e.lt;
        default: e.tk = !e.lt;
      endcase
      e.lat = N;
`ifdef BRANCH_EARLY_EXIT_EN
      x = a ^ b;
      for (int k = 1; k <= N; k++) begin
        if (((x >> ((N - k) * CHUNK)) & ((32'd1 << CHUNK) - 1)) != 0) begin
          e.lat = k;
          break;
        end
      end
`else
      x = 0;
`endif
    end
    return e;
  endfunction

  // Monitor: each rising out_valid is one result; pop and compare.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      seen = 1'b0;
    end else if (bif.out_valid && !seen) begin
      seen = 1'b1;
      if (q.size() == 0) begin
        chk("unexpected_result", 32'd1, 32'd0);
      end else begin
        e = q.pop_front();
        chk("illegal", bif.illegal, e.ill);
        chk("br_eq",   bif.br_eq,   e.eq);
        chk("br_lt",   bif.br_lt,   e.lt);
        chk("taken",   bif.taken,   e.tk);
        chk("latency", cyc - e.acc, e.lat);
        $display("result acc=%0d lat=%0d ill=%0b eq=%0b lt=%0b taken=%0b",
                 e.acc, cyc - e.acc, bif.illegal, bif.br_eq, bif.br_lt, bif.taken);
      end
    end else if (!bif.out_valid) begin
      seen = 1'b0;
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      case (rdy_mode)
        0:       bif.out_ready = 1'b0;
        1:       bif.out_ready = 1'b1;
        default: bif.out_ready = $urandom_range(0, 1);
      endcase
    end
  end

  task automatic send(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b, input bit push);
    int wt = 0;
    @(negedge clk);
    bif.funct3 = f3;
    bif.data_a = a;
    bif.data_b = b;
    bif.in_valid = 1'b1;
    while (!bif.in_ready && wt < 200) begin
      @(negedge clk);
      wt++;
    end
    if (!bif.in_ready) begin
      chk("accept_timeout", 32'(wt), 32'd0);
      bif.in_valid = 1'b0;
      return;
    end
    if (push) q.push_back(model(f3, a, b, cyc + 1));
    @(posedge clk);
    #1;
    bif.in_valid = 1'b0;
    bif.data_a = $urandom;
    bif.data_b = $urandom;
    bif.funct3 = 3'($urandom);
  endtask

  task automatic drain();
    int wt = 0;
    while ((q.size() != 0 || !bif.in_ready) && wt < 300) begin
      @(negedge clk);
      wt++;
    end
    chk("drain_queue", 32'(q.size()), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a, b, m;
    logic [2:0]  f3;
    int          k;
    bif.in_valid = 1'b0;
    bif.funct3 = 3'd0;
    bif.data_a = '0;
    bif.data_b = '0;
    bif.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready",  bif.in_ready,  1'b1);
    chk("rst_out_valid", bif.out_valid, 1'b0);
    chk("rst_br_eq",     bif.br_eq,     1'b0);
    chk("rst_br_lt",     bif.br_lt,     1'b0);
    chk("rst_taken",     bif.taken,     1'b0);
    chk("rst_illegal",   bif.illegal,   1'b0);

    // Directed sign/unsigned and equality cases.
    send(3'b100, 32'hFFFF_FFFF, 32'h0000_0001, 1);
    send(3'b110, 32'hFFFF_FFFF, 32'h0000_0001, 1);
    send(3'b111, 32'hFFFF_FFFF, 32'h0000_0001, 1);
    send(3'b000, 32'h1234_5678, 32'h1234_5678, 1);
    send(3'b001, 32'h1234_5678, 32'h1234_5678, 1);
    send(3'b101, 32'h8000_0000, 32'h7FFF_FFFF, 1);
    send(3'b100, 32'h1234_5600, 32'h1234_56FF, 1);
    drain();

    // Illegal op with the consumer stalled: result and in_ready must hold.
    rdy_mode = 0;
    send(3'b010, 32'h0000_0003, 32'h0000_0003, 1);
    k = 0;
    while (!bif.out_valid && k < 20) begin
      @(negedge clk);
      k++;
    end
    for (int i = 0; i < 5; i++) begin
      chk("stall_out_valid", bif.out_valid, 1'b1);
      chk("stall_illegal",   bif.illegal,   1'b1);
      chk("stall_taken",     bif.taken,     1'b0);
      chk("stall_br_eq",     bif.br_eq,     1'b0);
      chk("stall_in_ready",  bif.in_ready,  1'b0);
      @(negedge clk);
    end
    rdy_mode = 1;
    drain();

    // Reset pulsed mid-BUSY: op is abandoned and must never produce a result.
    send(3'b000, 32'hCAFE_F00D, 32'hCAFE_F00D, 0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_out_valid", bif.out_valid, 1'b0);
    chk("abort_in_ready",  bif.in_ready,  1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("abort_no_valid", bif.out_valid, 1'b0);
    end
    send(3'b101, 32'd5, 32'd5, 1);
    drain();

    // Randomized traffic with random backpressure.
    rdy_mode = 2;
    for (int n = 0; n < 250; n++) begin
      f3 = 3'($urandom);
      a = $urandom;
      case ($urandom_range(0, 3))
        0: b = $urandom;
        1: b = a;
        2: begin
          k = $urandom_range(0, N - 1);
          m = 32'($urandom_range(1, 255)) << (k * CHUNK);
          b = a ^ m;
        end
        default: begin
          a = 32'($signed($urandom_range(0, 7)) - 4);
          b = 32'($signed($urandom_range(0, 7)) - 4);
        end
      endcase
      send(f3, a, b, 1);
    end
    rdy_mode = 1;
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/branch_comp_seq.md
# branch_comp_seq

Parametrised, multi-cycle branch comparator for the RV32I decoder datapath; next generation of the combinational branch comparator. Accepts two XLEN-bit operands plus funct3 through a valid/ready handshake, compares them CHUNK bits per cycle from MSB to LSB, and returns BrEq, BrLT and a final taken decision for all six B-type conditions. Sits between the register-file read stage and PCSel logic, trading latency for comparator area.

## Interface
- XLEN, 32, operand width; must be a multiple of CHUNK
- CHUNK, 8, bits compared per cycle; N = XLEN/CHUNK compare cycles (N=1 legal)
- clk  input  1  rising-edge clock
- rst_n  input  1  reset; asynchronous, active-low
- in_valid  input  1  request valid
- in_ready  output  1  block can accept a request; high only in IDLE
- funct3  input  3  B-type funct3
- data_a  input  XLEN  rs1 value
- data_b  input  XLEN  rs2 value
- out_valid  output  1  result valid; held until out_ready
- out_ready  input  1  consumer accepts result
- br_eq  output  1  data_a == data_b
- br_lt  output  1  data_a < data_b, signed or unsigned per funct3
- taken  output  1  branch condition true
- illegal  output  1  funct3 is 010 or 011

## Operation
- States: IDLE, BUSY, DONE.
- IDLE: in_ready=1. On in_valid&&in_ready, capture operands and funct3; legal funct3 -> BUSY with chunk index N-1; illegal funct3 -> DONE with illegal=1, taken=0, br_eq=0, br_lt=0.
- Unsigned compare when funct3[2]&funct3[1]; otherwise signed.
- Signed mode: MSB of the top chunk is inverted on both operands before comparison; all other bits are compared unsigned.
- BUSY: compare chunk [idx*CHUNK +: CHUNK]. First differing chunk (MSB-first) latches lt = (a_chunk < b_chunk), eq=0; later chunks do not change lt. idx decrements. After chunk 0: if no difference, eq=1, lt=0; -> DONE.
- taken: 000 eq; 001 !eq; 100 lt; 101 !lt; 110 lt; 111 !lt.
- DONE: out_valid=1; br_eq, br_lt, taken, illegal stable. On out_ready -> IDLE. No same-cycle accept in DONE (in_ready=0).
- Operands that change on the input ports after the accept edge have no effect.

## Timing
- Reset: state IDLE; out_valid=0, br_eq=0, br_lt=0, taken=0, illegal=0; in_ready=1 (combinational from state).
- Accept at edge E0. Legal op without early exit: out_valid high from edge E0+N. Illegal op: out_valid high from edge E0+1.
- Result outputs are registered; meaningful only while out_valid=1.
- out_ready held high: DONE lasts one cycle; IDLE follows; peak throughput one op per N+2 cycles.
- out_ready low: DONE and all outputs hold indefinitely.
- rst_n asserted mid-BUSY or mid-DONE: operation is abandoned, outputs go to reset values immediately, no result is produced.
- in_valid with in_ready=0 is ignored; the requester holds in_valid.

## Configuration
- BRANCH_EARLY_EXIT_EN defined: BUSY exits to DONE on the edge ending the first differing chunk; out_valid from edge E0+k, where k is the 1-based MSB-first index of that chunk. Equal operands still take N cycles.
- Undefined: always N BUSY cycles regardless of data; fixed latency.

## Structure
- Package branch_pkg: funct3 constants (BEQ, BNE, BLT, BGE, BLTU, BGEU), state enum, helper computing N.
- Sub-module branch_chunk_cmp: combinational CHUNK-wide compare producing eq/lt, instantiated once in the datapath.
- Elaboration check: XLEN % CHUNK == 0 and CHUNK >= 1.

## Test plan
- Reset with rst_n=0, then release -> in_ready=1, out_valid=0, all result outputs 0.
- BLT (100), a=0xFFFFFFFF (-1), b=0x00000001, out_ready=1 -> br_lt=1, br_eq=0, taken=1; out_valid at E0+4, or E0+1 with early exit.
- BLTU (110), same operands -> br_lt=0, taken=0; BGEU (111) -> taken=1.
- BEQ (000), a=b=0x12345678 -> br_eq=1, taken=1, out_valid at E0+4 in both configurations; BNE (001) -> taken=0.
- funct3=010 -> illegal=1, taken=0, out_valid at E0+1; out_ready held low 5 cycles -> outputs stable, in_ready=0.
- rst_n pulsed low during BUSY -> out_valid never rises for that op; next BGE (101), a=5, b=5 -> taken=1.
